interconn_master_link: RTL and testbench

//  Master-side (Z7) endpoint of the board-to-board Interconn link to the S7 slave board.
//  - Receives the six raw Touhou key lines; synchronises and debounces them, and emits level plus press/release pulses.
//  - Drives the die-buzzer gate line as a timed, retriggerable pulse.
//  - Converts left/right PCM samples into 1-bit first-order delta-sigma streams for the slave's audio relay.

---
 rtl/interconn_pkg.sv | 33 +++
 rtl/key_debouncer.sv | 59 +++++
 rtl/interconn_master_link.sv | 137 +++++++++++++
 tb/tb_interconn_master_link.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interconn_pkg.sv
// Shared definitions for the Interconn master link: key indices, buzzer
// states, default timing constants and a counter-width helper.
package interconn_pkg;

  // Bit positions of the six Touhou key lines coming from the slave board.
  typedef enum int {
    KEY_Z     = 0,
    KEY_SHIFT = 1,
    KEY_UP    = 2,
    KEY_DOWN  = 3,
    KEY_LEFT  = 4,
    KEY_RIGHT = 5
  } key_idx_e;

  localparam int NUM_KEYS = int'(KEY_RIGHT) + 1;

  // Die-buzzer gate states; the state bit doubles as the buzzer_en output.
  typedef enum logic {
    IDLE = 1'b0,
    BUZZ = 1'b1
  } buzz_state_e;

  // Defaults sized for the 100 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms
  localparam int DEF_BUZZ_CYCLES     = 50_000_000; // 500 ms
  localparam int DEF_SAMPLE_W        = 16;

  // Width of a down/up counter that must hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key line: 2-FF synchroniser, mismatch counter and press/release
// pulse generation. key_level flips once the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer
  import interconn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sys_clk,
  input  logic reset_rtl_0,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          press_reg;
  logic          release_reg;

  // Synchronise the raw line, count consecutive disagreement, flip the level
  // and emit a one-cycle pulse in the first cycle of the new level.
  always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg   <= key_raw;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg   <= ~level_reg;
        press_reg   <= ~level_reg;
        release_reg <= level_reg;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/interconn_master_link.sv
// Master-side endpoint of the board-to-board Interconn link: debounced key
// inputs, a retriggerable die-buzzer gate and two first-order delta-sigma
// audio channels driving 1-bit streams to the slave's audio relay.
module interconn_master_link
  import interconn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BUZZ_CYCLES     = DEF_BUZZ_CYCLES,
  parameter int SAMPLE_W        = DEF_SAMPLE_W
) (
  input  logic                sys_clk,
  input  logic                reset_rtl_0,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  input  logic                die_trigger,
  output logic                buzzer_en,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pdm_l,
  output logic                pdm_r
);

  // ---------------------------------------------------------------- keys
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .sys_clk    (sys_clk),
      .reset_rtl_0(reset_rtl_0),
      .key_raw    (key_in[gi]),
      .key_level  (key_level[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi])
    );
  end

  // -------------------------------------------------------------- buzzer
  localparam int BW = cnt_width(BUZZ_CYCLES);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

  buzz_state_e   buzz_state_reg;
  logic [BW-1:0] buzz_cnt_reg;

  // Gate timer: a trigger (re)loads the full duration, expiry returns to IDLE.
  always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      buzz_state_reg <= IDLE;
      buzz_cnt_reg   <= '0;
    end else begin
      case (buzz_state_reg)
        IDLE: begin
          if (die_trigger) begin
            buzz_state_reg <= BUZZ;
            buzz_cnt_reg   <= BUZZ_LAST;
          end
        end
        BUZZ: begin
          if (die_trigger) begin
            buzz_cnt_reg <= BUZZ_LAST;
          end else if (buzz_cnt_reg == '0) begin
            buzz_state_reg <= IDLE;
          end else begin
            buzz_cnt_reg <= buzz_cnt_reg - BW'(1);
          end
        end
        default: begin
          buzz_state_reg <= IDLE;
          buzz_cnt_reg   <= '0;
        end
      endcase
    end
  end

  // The state flop itself is the gate, so the output is glitch-free.
  assign buzzer_en = (buzz_state_reg == BUZZ);

  // --------------------------------------------------------------- audio
  localparam logic [SAMPLE_W-1:0] SIGN_BIT = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic                ready_reg;
  logic                sample_load;
  logic [SAMPLE_W-1:0] sample_in [2];
  logic [1:0]          pdm_bits;

  // Ready rises on the first edge after reset and stays high: the
  // modulators accept a new pair every cycle.
  always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
    end
  end

  assign sample_load  = sample_valid & ready_reg;
  assign sample_ready = ready_reg;
  assign sample_in[0] = sample_l;
  assign sample_in[1] = sample_r;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [SAMPLE_W-1:0] hold_reg;
    logic [SAMPLE_W-1:0] offset_bin;
    logic [SAMPLE_W:0]   acc_reg;

    // Flipping the sign bit maps two's complement onto 0..2^W-1.
    assign offset_bin = hold_reg ^ SIGN_BIT;

    // Both channels capture on the same accepted handshake.
    always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
      if (!reset_rtl_0) begin
        hold_reg <= '0;
      end else if (sample_load) begin
        hold_reg <= sample_in[gi];
      end
    end

    // Carry out of the W-bit phase accumulator is the 1-bit stream; the
    // phase is never cleared on a sample change so no click is produced.
    always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
      if (!reset_rtl_0) begin
        acc_reg <= '0;
      end else begin
        acc_reg <= {1'b0, acc_reg[SAMPLE_W-1:0]} + {1'b0, offset_bin};
      end
    end

    assign pdm_bits[gi] = acc_reg[SAMPLE_W];
  end

  assign pdm_l = pdm_bits[0];
  assign pdm_r = pdm_bits[1];

endmodule

// File: tb/tb_interconn_master_link.sv
// Bench for interconn_master_link with short debounce/buzz timing.
// Key pulses go through an event scoreboard fed by a trace-based model;
// buzzer and key levels are compared every cycle by the monitor.
module tb_interconn_master_link;

  localparam int DEB   = 16;
  localparam int BUZ   = 32;
  localparam int SW    = 16;
  localparam int NK    = 6;
  localparam int N_AUD = 4096;

  logic          sys_clk = 1'b0;
  logic          reset_rtl_0 = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          die_trigger = 1'b0;
  logic          buzzer_en;
  logic [SW-1:0] sample_l = '0;
  logic [SW-1:0] sample_r = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          pdm_l;
  logic          pdm_r;

  interconn_master_link #(
    .DEBOUNCE_CYCLES(DEB),
    .BUZZ_CYCLES    (BUZ),
    .SAMPLE_W       (SW)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_rtl_0 (reset_rtl_0),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .die_trigger (die_trigger),
    .buzzer_en   (buzzer_en),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pdm_l       (pdm_l),
    .pdm_r       (pdm_r)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int base   = 0;
  bit mon_en = 1'b0;

  // Reference model state: raw key trace since reset, modelled levels,
  // time of last flip per key, time of last die trigger.
  logic [NK-1:0] hist[$];
  logic [NK-1:0] mdl_lvl;
  int            last_flip[NK];
  int            trig_rel;
  bit            mdl_buzz;

  typedef struct {
    int            e;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
  } ev_t;
  ev_t exp_q[$];

  int buzz_hi;
  int ones_l;
  int ones_r;

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, want, edge_n);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    exp_q.delete();
    mdl_lvl  = '0;
    for (int b = 0; b < NK; b++) last_flip[b] = 0;
    trig_rel = -100000;
    mdl_buzz = 1'b0;
    base     = edge_n;
  endfunction

  // A key flips at edge E when the raw samples taken at edges E-DEB-1..E-2
  // all differ from its level and at least DEB edges passed since its last flip.
  task automatic model_edge();
    int            rel;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic [NK-1:0] hv;
    bit            all_diff;
    logic          v;
    rel = edge_n - base;
    hist.push_back(key_in);
    p = '0;
    r = '0;
    for (int b = 0; b < NK; b++) begin
      if (rel - last_flip[b] >= DEB) begin
        all_diff = 1'b1;
        for (int j = rel - DEB - 1; j <= rel - 2; j++) begin
          if (j >= 1) begin
            hv = hist[j-1];
            v  = hv[b];
          end else begin
            v = 1'b0;
          end
          if (v == mdl_lvl[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (mdl_lvl[b]) r[b] = 1'b1;
          else            p[b] = 1'b1;
          mdl_lvl[b]   = ~mdl_lvl[b];
          last_flip[b] = rel;
        end
      end
    end
    if ((p | r) != '0) exp_q.push_back('{edge_n, p, r});
    if (die_trigger) trig_rel = rel;
    mdl_buzz = (rel >= trig_rel) && (rel - trig_rel < BUZ);
  endtask

  // One clock: model sees the inputs present at the edge, then sample outputs.
  task automatic tick();
    @(posedge sys_clk);
    edge_n++;
    if (reset_rtl_0) model_edge();
    #1;
    if (buzzer_en) buzz_hi++;
    ones_l += int'(pdm_l);
    ones_r += int'(pdm_r);
  endtask

  // Monitor: pops expected key events when the DUT shows a pulse.
  always @(negedge sys_clk) begin
    if (mon_en && reset_rtl_0) begin
      while (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
        total++;
        bad++;
        $display("FAIL key_pulse_missed: got none want press=%b release=%b at edge %0d",
                 exp_q[0].p, exp_q[0].r, exp_q[0].e);
        void'(exp_q.pop_front());
      end
      if ((key_press | key_release) != '0) begin
        total++;
        if (exp_q.size() == 0 || exp_q[0].e != edge_n) begin
          bad++;
          $display("FAIL key_pulse_unexpected: got press=%b release=%b want none at edge %0d",
                   key_press, key_release, edge_n);
        end else begin
          if (key_press != exp_q[0].p || key_release != exp_q[0].r) begin
            bad++;
            $display("FAIL key_pulse: got press=%b release=%b want press=%b release=%b at edge %0d",
                     key_press, key_release, exp_q[0].p, exp_q[0].r, edge_n);
          end else begin
            $display("key event edge %0d press=%b release=%b", edge_n, key_press, key_release);
          end
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
        total++;
        bad++;
        $display("FAIL key_pulse_missing: got none want press=%b release=%b at edge %0d",
                 exp_q[0].p, exp_q[0].r, edge_n);
        void'(exp_q.pop_front());
      end
      check("key_level", key_level, mdl_lvl);
      check("buzzer_en", buzzer_en, mdl_buzz);
    end
  end

  task automatic audio_seg(input logic [SW-1:0] sl, input logic [SW-1:0] sr);
    longint ul;
    longint ur;
    sample_l     = sl;
    sample_r     = sr;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    sample_l     = SW'($urandom);
    sample_r     = SW'($urandom);
    repeat (4) tick();
    ones_l = 0;
    ones_r = 0;
    repeat (N_AUD) tick();
    ul = longint'(sl ^ 16'h8000);
    ur = longint'(sr ^ 16'h8000);
    $display("audio segment l=%h r=%h ones_l=%0d ones_r=%0d", sl, sr, ones_l, ones_r);
    check_rng("pdm_l_density", ones_l, (N_AUD * ul) >> 16, (65535 + N_AUD * ul) >> 16);
    check_rng("pdm_r_density", ones_r, (N_AUD * ur) >> 16, (65535 + N_AUD * ur) >> 16);
  endtask

  initial begin
    model_reset();
    // Asynchronous reset before any clock edge.
    #1 reset_rtl_0 = 1'b0;
    #2;
    check("rst_key_level", key_level, 0);
    check("rst_key_press", key_press, 0);
    check("rst_key_release", key_release, 0);
    check("rst_buzzer", buzzer_en, 0);
    check("rst_pdm", {pdm_l, pdm_r}, 0);
    check("rst_ready", sample_ready, 0);
    repeat (2) tick();
    check("rst_ready_held", sample_ready, 0);
    #2 reset_rtl_0 = 1'b1;
    model_reset();
    mon_en = 1'b1;
    tick();
    check("ready_after_reset", sample_ready, 1);

    // 1: single key, exact latency.
    key_in[2] = 1'b1;
    repeat (17) tick();
    check("t1_before_flip", key_level, 0);
    tick();
    check("t1_level", key_level, 6'h04);
    check("t1_press", key_press, 6'h04);
    tick();
    check("t1_press_one_cycle", key_press, 0);

    // 2: short glitch is filtered.
    key_in[0] = 1'b1;
    repeat (10) tick();
    key_in[0] = 1'b0;
    repeat (30) tick();
    check("t2_level", key_level, 6'h04);

    // 3: two keys together, released 100 cycles later.
    key_in[1] = 1'b1;
    key_in[5] = 1'b1;
    repeat (18) tick();
    check("t3_press", key_press, 6'h22);
    repeat (82) tick();
    key_in[1] = 1'b0;
    key_in[5] = 1'b0;
    repeat (18) tick();
    check("t3_release", key_release, 6'h22);
    repeat (20) tick();

    // Random key activity with mixed hold times around the debounce limit.
    repeat (40) begin
      key_in = NK'($urandom);
      repeat ($urandom_range(1, 40)) tick();
    end
    key_in = 6'b010000;
    repeat (40) tick();

    // 4: single trigger, then retrigger 20 cycles later.
    buzz_hi = 0;
    die_trigger = 1'b1;
    tick();
    die_trigger = 1'b0;
    repeat (59) tick();
    check("t4_single", buzz_hi, BUZ);
    buzz_hi = 0;
    die_trigger = 1'b1;
    tick();
    die_trigger = 1'b0;
    repeat (19) tick();
    die_trigger = 1'b1;
    tick();
    die_trigger = 1'b0;
    repeat (70) tick();
    check("t4_retrigger", buzz_hi, BUZ + 20);

    // 5: modulator densities.
    audio_seg(16'h8000, SW'($urandom));
    audio_seg(16'h0000, SW'($urandom));
    audio_seg(16'h7FFF, SW'($urandom));
    audio_seg(SW'($urandom), SW'($urandom));

    // 6: reset between edges while buzzing and mid-debounce.
    key_in = 6'b011000;
    die_trigger = 1'b1;
    tick();
    die_trigger = 1'b0;
    repeat (8) tick();
    check("t6_pre_buzz", buzzer_en, 1);
    check("t6_pre_level", key_level, 6'h10);
    #2 reset_rtl_0 = 1'b0;
    #1;
    check("t6_level", key_level, 0);
    check("t6_press", key_press, 0);
    check("t6_release", key_release, 0);
    check("t6_buzzer", buzzer_en, 0);
    check("t6_pdm", {pdm_l, pdm_r}, 0);
    check("t6_ready", sample_ready, 0);
    key_in = '0;
    repeat (2) tick();
    #2 reset_rtl_0 = 1'b1;
    model_reset();
    tick();
    check("t6_ready_after", sample_ready, 1);
    repeat (40) tick();
    check("t6_buzzer_after", buzzer_en, 0);
    check("t6_level_after", key_level, 0);

    repeat (5) tick();
    check("events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
